// File: rtl/sample_feeder_if.sv
// rtl/sample_feeder_if.sv - sample path between acquisition source, feeder FIFO and filter
interface sample_feeder_if #(
    parameter int DATA_SIZE = 24,
    parameter int ADDR_W    = 4
);
    logic                 wr_en;
    logic [DATA_SIZE-1:0] wr_data;
    logic                 full;
    logic [ADDR_W:0]      level;
    logic [DATA_SIZE-1:0] data_out;
    logic                 sample;
    logic                 filter_done;

    modport slave (
        input  wr_en, wr_data, filter_done,
        output full, level, data_out, sample
    );

    modport master (
        output wr_en, wr_data, filter_done,
        input  full, level, data_out, sample
    );
endinterface

// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - FIFO-buffered sample feeder issuing one strobed sample per rate tick
module sample_feeder #(
    parameter int DATA_SIZE  = 24,
    parameter int DIV        = 50000,
    parameter int SAMPLE_LEN = 5,
    parameter int ADDR_W     = 4
) (
    input  logic           clk,
    input  logic           reset,
    sample_feeder_if.slave bus,
    input  logic           clr_flags,
    output logic           underrun,
    output logic           overrun,
    output logic           wr_drop
);
    localparam int CW    = $clog2(DIV);
    localparam int LW    = $clog2(SAMPLE_LEN + 1);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [CW-1:0]     CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [LW-1:0]     LEN_LAST = LW'(SAMPLE_LEN - 1);
    localparam logic [LW-1:0]     LEN_ONE  = LW'(1);
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [LW-1:0]        r_len;
    logic                 r_done;
    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]    r_wptr;
    logic [ADDR_W-1:0]    r_rptr;
    logic [ADDR_W:0]      r_level;
    logic [DATA_SIZE-1:0] r_dout;
    logic                 r_underrun;
    logic                 r_overrun;
    logic                 r_wr_drop;

    logic w_tick;
    logic w_idle_tick;
    logic w_pop;
    logic w_push;
    logic w_full;
    logic w_issue_end;
    logic w_done_seen;

    assign w_tick      = (r_cnt == CNT_LAST);
    assign w_idle_tick = (r_state == S_IDLE) && w_tick;
    assign w_pop       = w_idle_tick && (r_level != '0);
    assign w_full      = (r_level == LVL_FULL);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts the write then.
    assign w_push      = bus.wr_en && (!w_full || w_pop);
    assign w_issue_end = (r_state == S_ISSUE) && (r_len == LEN_LAST);
    assign w_done_seen = r_done || bus.filter_done;

    assign bus.full     = w_full;
    assign bus.level    = r_level;
    assign bus.data_out = r_dout;
    assign bus.sample   = (r_state == S_ISSUE);
    assign underrun     = r_underrun;
    assign overrun      = r_overrun;
    assign wr_drop      = r_wr_drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_tick) w_next = S_ISSUE;
            S_ISSUE:     if (r_len == LEN_LAST) w_next = w_done_seen ? S_IDLE : S_WAIT_DONE;
            S_WAIT_DONE: if (bus.filter_done) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= w_tick ? '0 : r_cnt + CNT_ONE;
            r_len  <= ((r_state == S_ISSUE) && !w_issue_end) ? r_len + LEN_ONE : '0;
            // An early completion is remembered only until the strobe ends.
            r_done <= (r_state == S_ISSUE) && !w_issue_end && w_done_seen;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_dout  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
                r_dout <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
            r_wr_drop  <= 1'b0;
        end else begin
            r_underrun <= (w_idle_tick && (r_level == '0)) || (r_underrun && !clr_flags);
            r_overrun  <= (w_tick && (r_state != S_IDLE)) || (r_overrun && !clr_flags);
            r_wr_drop  <= (bus.wr_en && w_full && !w_pop) || (r_wr_drop && !clr_flags);
        end
    end
endmodule

// File: tb/tb_sample_feeder.sv
// tb/tb_sample_feeder.sv - directed bench for sample_feeder against a queue-based model
module tb_sample_feeder;
    localparam int DW    = 24;
    localparam int DIV   = 40;
    localparam int SL    = 5;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clr_flags = 1'b0;
    logic underrun, overrun, wr_drop;

    sample_feeder_if #(.DATA_SIZE(DW), .ADDR_W(AW)) bus ();

    sample_feeder #(.DATA_SIZE(DW), .DIV(DIV), .SAMPLE_LEN(SL), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .clr_flags (clr_flags),
        .underrun  (underrun),
        .overrun   (overrun),
        .wr_drop   (wr_drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Behavioural model: FIFO as a queue, strobe as a remaining-cycle count.
    int            m_cnt  = 0;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout = '0;
    int            m_left = 0;
    bit            m_wait = 0, m_done = 0, m_under = 0, m_over = 0, m_drop = 0;

    always @(posedge clk) begin
        bit tick, busy, pop, push, fd, sd;
        if (!reset) begin
            m_cnt = 0; m_q.delete(); m_dout = '0; m_left = 0;
            m_wait = 0; m_done = 0; m_under = 0; m_over = 0; m_drop = 0;
        end else begin
            tick = (m_cnt == DIV - 1);
            busy = (m_left > 0) || m_wait;
            pop  = !busy && tick && (m_q.size() > 0);
            push = bus.wr_en && ((m_q.size() < DEPTH) || pop);
            fd   = bus.filter_done;
            if (m_left > 0) begin
                sd = m_done || fd;
                if (m_left == 1) begin m_wait = !sd; m_done = 0; end
                else m_done = sd;
                m_left--;
            end else if (m_wait) begin
                if (fd) m_wait = 0;
            end else if (tick) begin
                m_left = SL;
            end
            m_under = (!busy && tick && (m_q.size() == 0)) || (m_under && !clr_flags);
            m_over  = (tick && busy) || (m_over && !clr_flags);
            m_drop  = (bus.wr_en && (m_q.size() == DEPTH) && !pop) || (m_drop && !clr_flags);
            if (pop)  m_dout = m_q.pop_front();
            if (push) m_q.push_back(bus.wr_data);
            m_cnt = (m_cnt + 1) % DIV;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("sample",   bus.sample,   m_left > 0);
            chk("data_out", bus.data_out, m_dout);
            chk("level",    bus.level,    m_q.size());
            chk("full",     bus.full,     m_q.size() == DEPTH);
            chk("underrun", underrun,     m_under);
            chk("overrun",  overrun,      m_over);
            chk("wr_drop",  wr_drop,      m_drop);
        end
    end

    // Filter stand-in: completion pulse resp_delay cycles after each strobe rise (0 = withhold).
    int resp_delay = 20, resp_cnt = 0, man_req = 0, man_seen = 0;
    bit prev_s = 0;
    always @(negedge clk) begin
        bit fire;
        fire = 0;
        if (resp_cnt > 0) begin resp_cnt--; fire = (resp_cnt == 0); end
        if (bus.sample && !prev_s && resp_delay > 0) resp_cnt = resp_delay;
        if (man_seen != man_req) begin man_seen = man_req; fire = 1; end
        prev_s = bus.sample;
        bus.filter_done = fire;
    end

    int            cyc = 0, rises = 0, cur_w = 0, last_w = 0;
    int            rise_cyc[$];
    logic [DW-1:0] rise_q[$];
    bit            mprev = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.sample && !mprev) begin
            rises++; rise_q.push_back(bus.data_out); rise_cyc.push_back(cyc); cur_w = 1;
        end else if (bus.sample) cur_w++;
        else if (mprev) last_w = cur_w;
        mprev = bus.sample;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rises(input int n, input string nm);
        int target;
        target = rises + n;
        for (int k = 0; k < 3 * DIV * n && rises < target; k++) @(negedge clk);
        if (rises < target) chk(nm, rises, target);
    endtask

    task automatic push(input logic [DW-1:0] d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_data = d;
    endtask

    task automatic push_end();
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic clear_flags();
        @(negedge clk); clr_flags = 1'b1;
        @(negedge clk); clr_flags = 1'b0;
    endtask

    initial begin
        int n0, n;
        bus.wr_en = 1'b0; bus.wr_data = '0;
        cycles(3);
        chk("rst_sample", bus.sample, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_dout", bus.data_out, 0);
        chk("rst_flags", {underrun, overrun, wr_drop}, 0);
        reset = 1'b1;

        // Empty FIFO: strobes still issue, old data held, underrun flagged.
        wait_rises(2, "underrun_rise_timeout");
        cycles(2);
        chk("underrun_set", underrun, 1);
        chk("underrun_dout", bus.data_out, 0);
        clear_flags();
        chk("underrun_clr", underrun, 0);

        // Three boundary samples in order, DIV apart, SL wide, no flags.
        n0 = rises;
        push(24'h000001); push(24'h7FFFFF); push(24'h800000); push_end();
        wait_rises(3, "stream_rise_timeout");
        chk("stream_v0", rise_q[n0], 24'h000001);
        chk("stream_v1", rise_q[n0 + 1], 24'h7FFFFF);
        chk("stream_v2", rise_q[n0 + 2], 24'h800000);
        chk("stream_gap0", rise_cyc[n0 + 1] - rise_cyc[n0], DIV);
        chk("stream_gap1", rise_cyc[n0 + 2] - rise_cyc[n0 + 1], DIV);
        cycles(SL + 2);
        chk("stream_width", last_w, SL);
        chk("stream_flags", {underrun, overrun, wr_drop}, 0);

        // Completion during the strobe: back to idle without waiting.
        resp_delay = 1;
        push(24'h0A0A0A); push(24'h0B0B0B); push_end();
        wait_rises(1, "early_rise0_timeout");
        cycles(SL + 1);
        chk("early_width", last_w, SL);
        wait_rises(1, "early_rise1_timeout");
        cycles(2);
        chk("early_overrun", overrun, 0);
        chk("early_dout", bus.data_out, 24'h0B0B0B);
        resp_delay = 0;
        cycles(SL + 2);

        // Withheld completion: tick dropped, no pop.
        push(24'h123456); push(24'h654321); push_end();
        wait_rises(1, "hold_rise_timeout");
        cycles(DIV + 5);
        chk("hold_overrun", overrun, 1);
        chk("hold_level", bus.level, 1);
        chk("hold_dout", bus.data_out, 24'h123456);
        man_req++;
        wait_rises(1, "hold_release_timeout");
        chk("hold_next_dout", bus.data_out, 24'h654321);
        clear_flags();

        // Fill past depth while stuck waiting, then push coincident with a pop.
        for (int i = 0; i < 17; i++) push(24'h000100 + 24'(i));
        push_end();
        chk("fill_full", bus.full, 1);
        chk("fill_level", bus.level, 16);
        chk("fill_drop", wr_drop, 1);
        clear_flags();
        resp_delay = 20;
        man_req++;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!(m_cnt == DIV - 1 && m_left == 0 && !m_wait) && n < 3 * DIV);
        if (n >= 3 * DIV) chk("fill_tick_timeout", n, 0);
        bus.wr_en = 1'b1; bus.wr_data = 24'hABCDEF;
        @(negedge clk); bus.wr_en = 1'b0;
        chk("popfull_level", bus.level, 16);
        chk("popfull_full", bus.full, 1);
        chk("popfull_drop", wr_drop, 0);
        chk("popfull_dout", bus.data_out, 24'h000100);

        // Reset in the middle of a strobe.
        @(negedge clk); reset = 1'b0;
        cycles(2);
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) push(24'(i));
        push_end();
        wait_rises(1, "rst_rise_timeout");
        chk("rst_pre_level", bus.level, 3);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_sample", bus.sample, 0);
        chk("rst_mid_level", bus.level, 0);
        chk("rst_mid_dout", bus.data_out, 0);
        @(posedge clk); #3 reset = 1'b1;
        n = 1;
        do begin
            @(posedge clk); #1; n++;
        end while (!bus.sample && n < 3 * DIV);
        chk("rst_first_rise", n, DIV + 1);

        cycles(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter DATA_SIZE, default 24, sample width in bits.
REQ-002 Parameter DIV, default 50000, clk cycles per sample period (100 MHz / 2 kHz); legal range 8 or more.
REQ-003 Parameter SAMPLE_LEN, default 5, width of the sample strobe in clk cycles; legal range 1 to DIV-3.
REQ-004 Parameter ADDR_W, default 4, FIFO address width; depth is 2**ADDR_W.
REQ-005 clk  in  1  single system clock; all logic on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 wr_en  in  1  push wr_data into the FIFO this cycle.
REQ-008 wr_data  in  DATA_SIZE  sample from the acquisition source, two's complement.
REQ-009 filter_done  in  1  one-cycle completion pulse from the downstream filter.
REQ-010 clr_flags  in  1  synchronous clear of the sticky flags.
REQ-011 data_out  out  DATA_SIZE  sample presented to the filter data_in port.
REQ-012 sample  out  1  strobe to the filter; data_out is valid and stable while sample is high.
REQ-013 full  out  1  FIFO full; combinational from the occupancy count.
REQ-014 level  out  ADDR_W+1  FIFO occupancy, 0 to 2**ADDR_W.
REQ-015 underrun, overrun, wr_drop  out  1 each  sticky error flags.

Function
REQ-016 Rate counter counts 0 to DIV-1 and wraps; tick is asserted for the single cycle in which count equals DIV-1; the counter runs in every state.
REQ-017 FSM states are IDLE, ISSUE and WAIT_DONE.
REQ-018 IDLE with tick: pop the FIFO head into data_out if level > 0, then enter ISSUE at the next edge.
REQ-019 sample is high for exactly SAMPLE_LEN cycles, starting the cycle after the tick, and coincides exactly with ISSUE.
REQ-020 ISSUE is followed by WAIT_DONE; WAIT_DONE goes to IDLE on filter_done.
REQ-021 A filter_done pulse during ISSUE is latched, and ISSUE then exits directly to IDLE.
REQ-022 A filter_done pulse in IDLE is ignored.
REQ-023 data_out changes only on a pop and holds its value at all other times.
REQ-024 Tick in IDLE with level = 0: data_out keeps the previous sample, the sample strobe is still issued, and underrun is set.
REQ-025 Tick in ISSUE or WAIT_DONE: the tick is dropped, no pop occurs, overrun is set, and the state is unchanged.
REQ-026 wr_en with full and no pop in the same cycle: the write is discarded and wr_drop is set.
REQ-027 wr_en with full and a pop in the same cycle: the write is accepted and level stays unchanged.
REQ-028 Simultaneous push and pop at level = 0: the pop does not occur (underrun rule applies) and the push is stored, giving level = 1.
REQ-029 FIFO read and write pointers are ADDR_W bits wide and wrap modulo depth; level is updated +1 on push, -1 on pop, and unchanged on both.
REQ-030 Sticky flags clear on clr_flags; a set event in the same cycle as clr_flags wins.
REQ-031 No arithmetic is applied to samples; data passes bit-exact.

Reset
REQ-032 reset low asynchronously forces: state IDLE, rate counter 0, pointers 0, level 0, data_out 0, sample 0, all flags 0, latched done 0.
REQ-033 Assertion of reset mid-ISSUE drops sample within the same cycle; after release the first tick occurs DIV cycles later.
REQ-034 FIFO storage contents are not reset.

Verification
REQ-035 Push 0x000001, 0x7FFFFF, 0x800000; filter_done is returned 20 cycles after each sample rise -> data_out shows the three values in order, sample is 5 cycles wide, sample rises DIV cycles apart, and no flags are set.
REQ-036 Push nothing, run 2 ticks -> sample still pulses, data_out = 0, and underrun = 1.
REQ-037 filter_done is withheld for more than DIV cycles -> overrun = 1, no pop occurs, and level is unchanged.
REQ-038 Push 17 words at depth 16 -> full = 1, level = 16, and wr_drop = 1; a push coincident with a pop while full -> the write is accepted and level stays 16.
REQ-039 Assert reset during ISSUE with level = 3 -> sample = 0 immediately and level = 0; after release the first sample rises DIV+1 cycles later.
REQ-040 filter_done is returned on the second cycle of ISSUE -> the FSM returns to IDLE after 5 cycles, with no WAIT_DONE visit.
